// File: rtl/pipeline_run_controller.sv
// Run sequencer for the 20-bit pipelined core.
// It loads a data-memory image, runs the core to halt or watchdog, drains, then dumps memory.
`timescale 1ns/1ps
module pipeline_run_controller #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter int DRAIN_CYCLES  = 4,
    parameter int MAX_CYCLES    = 20000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     core_rst,
    output logic                     core_run,
    input  logic                     core_halt,
    output logic                     mem_sel,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    input  logic                     out_ready,
    output logic [15:0]              cycle_count,
    output logic                     timeout,
    output logic                     done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DUMP,
        DONE
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR      = ADDRESS_WIDTH'(MEM_SIZE - 1);
    localparam logic [15:0]              DRAIN_LAST     = 16'(DRAIN_CYCLES - 1);
    localparam logic [31:0]              WATCHDOG_LIMIT = 32'(MAX_CYCLES);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE       = ADDRESS_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [15:0]              cycle_count_q, cycle_count_d;
    logic                     timeout_q, timeout_d;
    logic                     done_q, done_d;
    logic [15:0]              drain_cnt_q, drain_cnt_d;
    logic                     first_rd_q, first_rd_d;
    logic                     rd_pending_q, rd_pending_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            done_q        <= 1'b0;
            drain_cnt_q   <= '0;
            first_rd_q    <= 1'b0;
            rd_pending_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            done_q        <= done_d;
            drain_cnt_q   <= drain_cnt_d;
            first_rd_q    <= first_rd_d;
            rd_pending_q  <= rd_pending_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_addr_q    <= out_addr_d;
        end
    end

    // The host owns memory and the core is held in reset unless a state says otherwise.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        done_d        = done_q;
        drain_cnt_d   = drain_cnt_q;
        first_rd_d    = 1'b0;
        rd_pending_d  = 1'b0;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_addr_d    = out_addr_q;
        load_ready    = 1'b0;
        core_rst      = 1'b1;
        core_run      = 1'b0;
        mem_sel       = 1'b1;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = LOAD;
                    ptr_d         = '0;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
                    done_d        = 1'b0;
                end
            end

            LOAD: begin
                load_ready = 1'b1;
                mem_addr   = ptr_q;
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = load_data;
                    ptr_d     = ptr_q + ADDR_ONE;
                    if (load_last || ptr_q == LAST_ADDR) begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                core_rst = 1'b0;
                core_run = 1'b1;
                mem_sel  = 1'b0;
                if (cycle_count_q != 16'hFFFF) begin
                    cycle_count_d = cycle_count_q + 16'd1;
                end
                // A retiring halt takes priority over a watchdog expiring in the same cycle.
                if (core_halt) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else if ({16'd0, cycle_count_d} == WATCHDOG_LIMIT) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                    timeout_d   = 1'b1;
                end
            end

            DRAIN: begin
                core_rst    = 1'b0;
                core_run    = 1'b1;
                mem_sel     = 1'b0;
                drain_cnt_d = drain_cnt_q + 16'd1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d    = DUMP;
                    ptr_d      = '0;
                    first_rd_d = 1'b1;
                end
            end

            DUMP: begin
                core_rst = 1'b0;
                mem_addr = ptr_q;
                if (first_rd_q) begin
                    mem_re       = 1'b1;
                    rd_pending_d = 1'b1;
                end
                if (rd_pending_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_rdata;
                    out_addr_d  = ptr_q;
                end
                // The next read goes out in the handshake cycle, giving one word every two cycles.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d        = ptr_q + ADDR_ONE;
                        mem_addr     = ptr_q + ADDR_ONE;
                        mem_re       = 1'b1;
                        rd_pending_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_addr    = out_addr_q;
    assign cycle_count = cycle_count_q;
    assign timeout     = timeout_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench for pipeline_run_controller: random load images, pipeline stores,
// halts and watchdogs, and dump back-pressure are compared against an image-level memory model.
`timescale 1ns/1ps
module tb_pipeline_run_controller;
    localparam int DW   = 20;
    localparam int AW   = 8;
    localparam int MS   = 256;
    localparam int DC   = 4;
    localparam int MAXC = 100;

    logic          clk = 1'b0;
    logic          rst, start, load_valid, load_last, load_ready;
    logic          core_rst, core_run, core_halt, mem_sel, mem_we, mem_re;
    logic          out_valid, out_ready, timeout, done;
    logic [DW-1:0] load_data, mem_wdata, mem_rdata, out_data;
    logic [AW-1:0] mem_addr, out_addr;
    logic [15:0]   cycle_count;

    logic [DW-1:0] mem      [MS];
    logic [DW-1:0] init_img [MS];
    logic [DW-1:0] exp_mem  [MS];
    logic          mem_init, pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wdata;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    pipeline_run_controller #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS),
        .DRAIN_CYCLES(DC), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .core_rst(core_rst), .core_run(core_run), .core_halt(core_halt),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
        .cycle_count(cycle_count), .timeout(timeout), .done(done)
    );

    // Data memory shared by the controller port and the pipeline store port.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MS; i++) mem[i] <= init_img[i];
        end else begin
            if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
            if (!mem_sel && pipe_we) mem[pipe_addr] <= pipe_wdata;
        end
        if (mem_sel && mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic drive_store();
        pipe_we    = ($urandom_range(0, 7) == 0);
        pipe_addr  = AW'($urandom);
        pipe_wdata = DW'($urandom);
        if (pipe_we) exp_mem[pipe_addr] = pipe_wdata;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        mem_init = 1'b0; start = 1'b1; load_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; #1;
        checks++;
        if ({core_rst, core_run, mem_sel, mem_we, mem_re, load_ready} !== 6'b101000) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 101000", {core_rst, core_run, mem_sel, mem_we, mem_re, load_ready});
        end
        checks++;
        if ({out_valid, timeout, done} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {out_valid, timeout, done});
        end
        checks++;
        if ({mem_addr, mem_wdata, out_addr, out_data, cycle_count} !== '0) begin
            errors++; $display("[TB] FAIL reset_regs: got %0h expected 0", {mem_addr, mem_wdata, out_addr, out_data, cycle_count});
        end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        checks++;
        if ({mem_we, load_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL idle_ignores_load: got %b expected 00", {mem_we, load_ready});
        end
        @(posedge clk); #1;
        load_valid = 1'b0; #1;
        checks++;
        if ({load_ready, core_rst} !== 2'b01) begin
            errors++; $display("[TB] FAIL idle_stays: got %b expected 01", {load_ready, core_rst});
        end
    endtask

    task automatic test_start();
        @(posedge clk); #1;
        start = 1'b1; load_valid = 1'b0; out_ready = 1'b0; core_halt = 1'b0; #1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL start_same_cycle: got %b expected 0", load_ready);
        end
        @(posedge clk); #1;
        start = 1'b0; #1;
        checks++;
        if ({load_ready, core_rst, mem_sel} !== 3'b111) begin
            errors++; $display("[TB] FAIL start_load_ctrl: got %b expected 111", {load_ready, core_rst, mem_sel});
        end
        checks++;
        if ({cycle_count, timeout, done} !== 18'h0) begin
            errors++; $display("[TB] FAIL start_clears: got %0h expected 0", {cycle_count, timeout, done});
        end
    endtask

    task automatic test_load(input int n, input bit fixed, input bit use_last);
        logic [DW-1:0] fw [3];
        logic [DW-1:0] d;
        logic          v;
        int            i;
        int            guard;
        fw[0] = 20'h00001; fw[1] = 20'h00002; fw[2] = 20'hABCDE;
        i = 0; guard = 0;
        while (i < n && guard < 4 * MS) begin
            @(posedge clk); #1;
            guard++;
            v = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
            d = fixed ? fw[i % 3] : DW'($urandom);
            start = fixed ? 1'b0 : 1'($urandom_range(0, 1));
            load_valid = v; load_data = d; load_last = use_last && (i == n - 1);
            #1;
            checks++;
            if ({load_ready, core_rst, mem_sel, core_run} !== 4'b1110) begin
                errors++; $display("[TB] FAIL load_ctrl: got %b expected 1110", {load_ready, core_rst, mem_sel, core_run});
            end
            checks++;
            if (v) begin
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(i), d}) begin
                    errors++; $display("[TB] FAIL load_write: got %0h expected %0h", {mem_we, mem_addr, mem_wdata}, {1'b1, AW'(i), d});
                end
                exp_mem[i] = d;
                i++;
            end else if (mem_we !== 1'b0) begin
                errors++; $display("[TB] FAIL load_gap_we: got %b expected 0", mem_we);
            end
        end
    endtask

    task automatic test_run(input int halt_after);
        bit halted;
        int end_k;
        halted = (halt_after > 0 && halt_after <= MAXC);
        end_k  = halted ? halt_after : MAXC;
        for (int k = 1; k <= end_k; k++) begin
            @(posedge clk); #1;
            core_halt = (k == halt_after);
            start = 1'($urandom_range(0, 1)); load_valid = 1'($urandom_range(0, 1)); load_last = 1'b0;
            drive_store();
            #1;
            checks++;
            if ({core_rst, core_run, mem_sel, load_ready, mem_we} !== 5'b01000) begin
                errors++; $display("[TB] FAIL run_ctrl: cycle %0d got %b expected 01000", k, {core_rst, core_run, mem_sel, load_ready, mem_we});
            end
            checks++;
            if ({cycle_count, timeout} !== {16'(k - 1), 1'b0}) begin
                errors++; $display("[TB] FAIL run_count: got %0h expected %0h", {cycle_count, timeout}, {16'(k - 1), 1'b0});
            end
        end
        for (int j = 1; j <= DC; j++) begin
            @(posedge clk); #1;
            core_halt = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1)); load_valid = 1'($urandom_range(0, 1));
            drive_store();
            #1;
            checks++;
            if ({core_rst, core_run, mem_sel, mem_re, mem_we} !== 5'b01000) begin
                errors++; $display("[TB] FAIL drain_ctrl: drain %0d got %b expected 01000", j, {core_rst, core_run, mem_sel, mem_re, mem_we});
            end
            checks++;
            if ({cycle_count, timeout} !== {16'(end_k), !halted}) begin
                errors++; $display("[TB] FAIL drain_status: got %0h expected %0h", {cycle_count, timeout}, {16'(end_k), !halted});
            end
        end
        @(posedge clk); #1;
        core_halt = 1'b0; pipe_we = 1'b0; load_valid = 1'b0; start = 1'($urandom_range(0, 1)); #1;
        checks++;
        if ({core_rst, core_run, mem_sel, mem_re, out_valid} !== 5'b00110) begin
            errors++; $display("[TB] FAIL dump_first_ctrl: got %b expected 00110", {core_rst, core_run, mem_sel, mem_re, out_valid});
        end
        checks++;
        if (mem_addr !== '0) begin
            errors++; $display("[TB] FAIL dump_first_addr: got %0h expected 0", mem_addr);
        end
    endtask

    // mode 0: sink always ready, mode 1: random ready, mode 2: ready except a 5-cycle stall at stall_addr.
    task automatic test_dump(input int mode, input int stall_addr, input int abort_addr);
        int            e, since_rd, stall_cnt;
        bit            prev_valid, prev_ready, hs_prev, finished, rdy, hs, exp_re;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_addr;
        e = 0; since_rd = 0; stall_cnt = 0;
        prev_valid = 0; prev_ready = 0; hs_prev = 0; finished = 0;
        prev_data = '0; prev_addr = '0;
        for (int cyc = 0; cyc < 4 * MS + 50 && !finished; cyc++) begin
            @(posedge clk); #1;
            if (hs_prev && e == MS) begin
                start = 1'b0; out_ready = 1'b0; load_valid = 1'b1; core_halt = 1'b0; #1;
                checks++;
                if ({done, out_valid, mem_re, mem_we, core_rst, mem_sel} !== 6'b100011) begin
                    errors++; $display("[TB] FAIL dump_done: got %b expected 100011", {done, out_valid, mem_re, mem_we, core_rst, mem_sel});
                end
                finished = 1;
            end else if (abort_addr >= 0 && out_valid === 1'b1 && e == abort_addr) begin
                rst = 1'b1; start = 1'b0; out_ready = 1'b0; core_halt = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0; #1;
                checks++;
                if ({out_valid, done, timeout, load_ready, core_rst, core_run, mem_sel, mem_re} !== 8'b00001010) begin
                    errors++; $display("[TB] FAIL abort_ctrl: got %b expected 00001010", {out_valid, done, timeout, load_ready, core_rst, core_run, mem_sel, mem_re});
                end
                checks++;
                if ({cycle_count, out_data, out_addr} !== '0) begin
                    errors++; $display("[TB] FAIL abort_regs: got %0h expected 0", {cycle_count, out_data, out_addr});
                end
                finished = 1;
            end else begin
                rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (e == stall_addr && out_valid === 1'b1 && stall_cnt < 5) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end
                out_ready = rdy;
                start = 1'($urandom_range(0, 1)); load_valid = 1'($urandom_range(0, 1)); core_halt = 1'($urandom_range(0, 1));
                #1;
                since_rd++;
                checks++;
                if ({core_run, core_rst, mem_sel, mem_we} !== 4'b0010) begin
                    errors++; $display("[TB] FAIL dump_ctrl: got %b expected 0010", {core_run, core_rst, mem_sel, mem_we});
                end
                if (since_rd == 1) begin
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++; $display("[TB] FAIL dump_valid_early: got %b expected 0", out_valid);
                    end
                end
                if (since_rd == 2) begin
                    checks++;
                    if (out_valid !== 1'b1) begin
                        errors++; $display("[TB] FAIL dump_valid_late: got %b expected 1", out_valid);
                    end
                end
                if (prev_valid && !prev_ready) begin
                    checks++;
                    if ({out_valid, out_data, out_addr} !== {1'b1, prev_data, prev_addr}) begin
                        errors++; $display("[TB] FAIL dump_hold: got %0h expected %0h", {out_valid, out_data, out_addr}, {1'b1, prev_data, prev_addr});
                    end
                end
                if (out_valid === 1'b1) begin
                    checks++;
                    if ({out_addr, out_data} !== {AW'(e), exp_mem[e % MS]} || e >= MS) begin
                        errors++; $display("[TB] FAIL dump_word: got %0h expected %0h", {out_addr, out_data}, {AW'(e), exp_mem[e % MS]});
                    end
                end
                hs = (out_valid === 1'b1) && rdy;
                exp_re = hs && (e != MS - 1);
                checks++;
                if (mem_re !== exp_re) begin
                    errors++; $display("[TB] FAIL dump_re: word %0d got %b expected %b", e, mem_re, exp_re);
                end
                if (exp_re) begin
                    checks++;
                    if (mem_addr !== AW'(e + 1)) begin
                        errors++; $display("[TB] FAIL dump_re_addr: got %0h expected %0h", mem_addr, AW'(e + 1));
                    end
                end
                if (mem_re === 1'b1) since_rd = 0;
                prev_valid = (out_valid === 1'b1); prev_ready = rdy;
                prev_data = out_data; prev_addr = out_addr;
                if (hs) e++;
                hs_prev = hs;
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("[TB] FAIL dump_timeout: got %0d words expected %0d", e, MS);
        end
        out_ready = 1'b0; load_valid = 1'b0; core_halt = 1'b0; start = 1'b0;
    endtask

    task automatic test_done_hold(input int exp_count, input bit exp_timeout);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            load_valid = 1'b1; start = 1'b0; out_ready = 1'b1; #1;
            checks++;
            if ({done, load_ready, mem_we, mem_re, out_valid, core_rst} !== 6'b100001) begin
                errors++; $display("[TB] FAIL done_hold: got %b expected 100001", {done, load_ready, mem_we, mem_re, out_valid, core_rst});
            end
            checks++;
            if ({cycle_count, timeout} !== {16'(exp_count), exp_timeout}) begin
                errors++; $display("[TB] FAIL done_status: got %0h expected %0h", {cycle_count, timeout}, {16'(exp_count), exp_timeout});
            end
        end
        load_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_start();
        test_load(1, 1'b0, 1'b1);
        test_run(1);
        test_dump(0, -1, -1);
        test_done_hold(1, 1'b0);
    endtask

    initial begin
        int h;
        rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        core_halt = 1'b0; out_ready = 1'b0; mem_init = 1'b1;
        pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        for (int i = 0; i < MS; i++) begin
            init_img[i] = DW'($urandom);
            exp_mem[i]  = init_img[i];
        end
        test_reset();

        $display("[TB] sequence 1: fixed three-word load, halt after 50 cycles, streaming dump");
        test_start();
        test_load(3, 1'b1, 1'b1);
        test_run(50);
        test_dump(0, -1, -1);
        test_done_hold(50, 1'b0);

        $display("[TB] sequence 2: watchdog expiry, dump stalled at address 7");
        test_start();
        test_load($urandom_range(5, 20), 1'b0, 1'b1);
        test_run(0);
        test_dump(2, 7, -1);
        test_done_hold(MAXC, 1'b1);

        $display("[TB] sequence 3: halt coincident with watchdog, reset mid-dump at address 40");
        test_start();
        test_load($urandom_range(1, 20), 1'b0, 1'b1);
        test_run(MAXC);
        test_dump(1, -1, 40);

        $display("[TB] sequence 4: full image load without last marker, random sink");
        h = $urandom_range(1, 60);
        test_start();
        test_load(MS, 1'b0, 1'b0);
        test_run(h);
        test_dump(1, -1, -1);
        test_done_hold(h, 1'b0);

        $display("[TB] sequence 5: restart straight from DONE");
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Top-level sequencer for the 20-bit pipelined core. It loads an initial data-memory image from a host stream, releases the pipeline and runs it until a halt or a watchdog timeout, and drains in-flight stores. It then streams the full data memory back out with a valid/ready handshake. It owns the data-memory port select, so the host and the pipeline never access memory in the same cycle.

## Interface
- DATA_WIDTH, 20, data-memory word width
- ADDRESS_WIDTH, 8, data-memory address width
- MEM_SIZE, 256, number of data-memory words loaded/dumped address space
- DRAIN_CYCLES, 4, cycles the pipeline keeps running after halt
- MAX_CYCLES, 20000, watchdog limit on RUN cycles
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin load/run/dump sequence (sampled in IDLE or DONE only)
- load_valid  in  1  host image word present
- load_data  in  DATA_WIDTH  host image word
- load_last  in  1  marks final image word
- load_ready  out  1  controller accepts image words
- core_rst  out  1  holds pipeline in reset
- core_run  out  1  pipeline may advance (gates PCWrite/IF_ID_Write)
- core_halt  in  1  pipeline reports halt instruction retired
- mem_sel  out  1  0 = pipeline owns data memory, 1 = controller owns it
- mem_addr  out  ADDRESS_WIDTH  controller memory address
- mem_wdata  out  DATA_WIDTH  controller write data
- mem_we  out  1  controller write strobe
- mem_re  out  1  controller read strobe
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_re
- out_valid  out  1  dump word valid
- out_data  out  DATA_WIDTH  dump word
- out_addr  out  ADDRESS_WIDTH  address of dump word
- out_ready  in  1  sink accepts dump word
- cycle_count  out  16  RUN cycles of the last run, saturating at 16'hFFFF
- timeout  out  1  last run ended by the watchdog
- done  out  1  dump complete

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DUMP, DONE.
- Reset values: state IDLE, core_rst=1, core_run=0, mem_sel=1, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, load_ready=0, out_valid=0, out_data=0, out_addr=0, cycle_count=0, timeout=0, done=0.
- IDLE/DONE: core_rst=1, mem_sel=1. start=1 moves to LOAD, sets the load pointer to 0, and clears cycle_count, timeout and done.
- LOAD: load_ready=1 and core_rst=1. When load_valid=1, the cycle has mem_we=1, mem_addr=pointer and mem_wdata=load_data (combinational), and the pointer increments. After an accepted word with load_last=1, or an accepted word at pointer MEM_SIZE-1, the state moves to RUN. Unloaded words keep their prior contents.
- RUN: core_rst=0, core_run=1, mem_sel=0. cycle_count increments every RUN cycle. core_halt=1 moves to DRAIN. If cycle_count reaches MAX_CYCLES after its increment and core_halt=0, the state moves to DRAIN with timeout=1. When halt and the watchdog occur in the same cycle, halt wins and timeout stays 0.
- DRAIN: core_rst=0, core_run=1, mem_sel=0 for exactly DRAIN_CYCLES cycles, then the state moves to DUMP.
- DUMP: core_run=0, core_rst=0 (pipeline frozen, state preserved), mem_sel=1. The read pointer starts at 0. The controller issues mem_re with mem_addr=pointer, registers mem_rdata into out_data and the pointer into out_addr, and raises out_valid. out_valid, out_data and out_addr stay stable until out_valid&&out_ready. In the handshake cycle the controller issues the next read. After the handshake on address MEM_SIZE-1 the state moves to DONE.
- DONE: done=1 holds until start or rst.
- start is ignored in LOAD/RUN/DRAIN/DUMP. load_valid is ignored outside LOAD. core_halt is ignored outside RUN.
- rst at any point, including mid-LOAD or mid-DUMP, returns to IDLE with reset values in the next cycle. Any pending out_valid drops.

## Timing
- start=1 in cycle t gives load_ready=1 in t+1.
- Last word accepted in t gives state RUN in t+1, with core_rst=0 and mem_sel=0.
- core_halt=1 in cycle t:
  - DRAIN covers t+1 through t+DRAIN_CYCLES.
  - DUMP starts at t+DRAIN_CYCLES+1, with the first mem_re in that cycle.
  - cycle_count includes cycle t.
- mem_re in cycle r gives out_valid=1 from r+2.
- A handshake in cycle h gives out_valid=0 in h+1 and the next out_valid in h+2. Maximum throughput is one word per 2 cycles.
- The final handshake in cycle h gives done=1 in h+1.

## Test plan
- Load 3 words (0x00001, 0x00002, 0xABCDE, with load_last on the third) -> 3 mem_we pulses at addresses 0, 1, 2 with matching data, then RUN on the next cycle with core_rst=0.
- core_halt pulse after 50 RUN cycles, DRAIN_CYCLES=4 -> cycle_count=50, timeout=0, core_run=1 for 4 more cycles, then the first mem_re at addr 0.
- Hold core_halt=0 with MAX_CYCLES=100 -> DRAIN entered after cycle_count=100 and timeout=1; core_halt and the watchdog in the same cycle give timeout=0.
- Dump with out_ready tied 1 -> 256 words, out_addr 0..255 in order matching the memory model, done=1 one cycle after addr 255.
- Dump with out_ready low for 5 cycles at addr 7 -> out_data and out_addr held stable and no further mem_re until the handshake.
- rst asserted mid-DUMP at addr 40, then start -> IDLE reset values next cycle, and a full fresh sequence completes with cycle_count cleared.
